sha3_block_packer: RTL

Downstream consumer of the 128-in/64-out bus FIFO in the SHA3 burst-master datapath. It pops 64-bit message words from the FIFO and assembles them into 1088-bit SHA3-256 rate blocks (17 lanes × 64 b). It applies SHA3 multi-rate padding (0x06 … 0x80) to the final block and hands each block to the Keccak absorb stage over a valid/ready handshake.

---
 rtl/sha3_pkg.sv | 21 ++
 rtl/sha3_pad_insert.sv | 26 ++
 rtl/sha3_block_packer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3 datapath constants, padding bytes and FSM state encoding.
// The state encoding is also used by the Keccak control.
package sha3_pkg;

  localparam int unsigned RATE_BYTES = 136;
  localparam int unsigned RATE_LANES = 17;
  localparam int unsigned LANE_W     = 64;
  localparam int unsigned BLOCK_W    = RATE_LANES * LANE_W;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef logic [2:0] sha3_state_t;

  localparam sha3_state_t StIdle = 3'd0;
  localparam sha3_state_t StFill = 3'd1;
  localparam sha3_state_t StPad  = 3'd2;
  localparam sha3_state_t StEmit = 3'd3;
  localparam sha3_state_t StDone = 3'd4;

endpackage

// File: rtl/sha3_pad_insert.sv
// SHA3 multi-rate padding: XOR the domain byte at the message tail offset
// and the final-bit byte into the last byte of the rate block.
module sha3_pad_insert
  import sha3_pkg::*;
#(
  parameter int unsigned BlockW = BLOCK_W
) (
  input  logic [BlockW-1:0] block_i,
  input  logic [31:0]       pad_off_i,
  output logic [BlockW-1:0] block_o
);

  localparam int unsigned NBytes = BlockW / 8;

  always_comb begin
    block_o = block_i;
    for (int unsigned k = 0; k < NBytes; k++) begin
      if (pad_off_i == k) begin
        block_o[8*k +: 8] = block_o[8*k +: 8] ^ PAD_DOMAIN;
      end
    end
    // Applied after the domain byte so a shared byte 135 becomes 0x86.
    block_o[BlockW-8 +: 8] = block_o[BlockW-8 +: 8] ^ PAD_FINAL;
  end

endmodule

// File: rtl/sha3_block_packer.sv
// Pops 64-bit message words from the bus FIFO, packs them into SHA3-256 rate
// blocks, pads the final block and hands blocks to the absorb stage.
module sha3_block_packer
  import sha3_pkg::*;
#(
  parameter int unsigned RateLanes = RATE_LANES,
  parameter int unsigned LaneW     = LANE_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [31:0]                   msg_bytes_i,
  output logic                          fifo_read_en_o,
  input  logic [LaneW-1:0]              fifo_read_data_i,
  input  logic                          fifo_empty_i,
  output logic [RateLanes*LaneW-1:0]    block_data_o,
  output logic                          block_valid_o,
  input  logic                          block_ready_i,
  output logic                          block_last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned BlockW    = RateLanes * LaneW;
  localparam int unsigned RateBytes = BlockW / 8;
  localparam int unsigned LaneIdxW  = $clog2(RateLanes + 1);
  localparam int unsigned RemW      = $clog2(LaneW / 8);

  sha3_state_t         state_q, state_d;
  logic [RemW-1:0]     msg_rem_q, msg_rem_d;
  logic [31:0]         words_total_q, words_total_d;
  logic [31:0]         words_issued_q, words_issued_d;
  logic [31:0]         pad_off_q, pad_off_d;
  logic                boundary_q, boundary_d;
  logic [LaneIdxW-1:0] lane_issue_q, lane_issue_d;
  logic [LaneIdxW-1:0] lane_cap_q, lane_cap_d;
  logic                cap_q, cap_d;
  logic                cap_last_q, cap_last_d;
  logic [BlockW-1:0]   buf_q, buf_d;
  logic                block_last_q, block_last_d;

  logic              pop;
  logic [LaneW-1:0]  lane_mask;
  logic [BlockW-1:0] padded;

  assign pop = (state_q == StFill) && !fifo_empty_i && (words_issued_q < words_total_q) &&
               (lane_issue_q < LaneIdxW'(RateLanes));

  // Only the final word of a message with a partial tail gets its upper bytes cleared.
  always_comb begin
    lane_mask = '1;
    if (cap_last_q && (msg_rem_q != '0)) begin
      lane_mask = ~({LaneW{1'b1}} << {msg_rem_q, 3'b000});
    end
  end

  sha3_pad_insert #(
    .BlockW (BlockW)
  ) u_pad_insert (
    .block_i   (buf_q),
    .pad_off_i (pad_off_q),
    .block_o   (padded)
  );

  always_comb begin
    state_d        = state_q;
    msg_rem_d      = msg_rem_q;
    words_total_d  = words_total_q;
    words_issued_d = words_issued_q;
    pad_off_d      = pad_off_q;
    boundary_d     = boundary_q;
    lane_issue_d   = lane_issue_q;
    lane_cap_d     = lane_cap_q;
    cap_d          = 1'b0;
    cap_last_d     = 1'b0;
    buf_d          = buf_q;
    block_last_d   = block_last_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          msg_rem_d      = msg_bytes_i[RemW-1:0];
          words_total_d  = 32'((33'(msg_bytes_i) + 33'(LaneW / 8 - 1)) >> RemW);
          words_issued_d = '0;
          pad_off_d      = msg_bytes_i % RateBytes;
          boundary_d     = (msg_bytes_i != '0) && ((msg_bytes_i % RateBytes) == '0);
          lane_issue_d   = '0;
          lane_cap_d     = '0;
          buf_d          = '0;
          block_last_d   = 1'b0;
          state_d        = (msg_bytes_i == '0) ? StPad : StFill;
        end
      end
      StFill: begin
        if (pop) begin
          cap_d          = 1'b1;
          lane_cap_d     = lane_issue_q;
          cap_last_d     = (words_issued_q + 32'd1 == words_total_q);
          words_issued_d = words_issued_q + 32'd1;
          lane_issue_d   = lane_issue_q + LaneIdxW'(1);
        end
        if (cap_q) begin
          buf_d[32'(lane_cap_q) * LaneW +: LaneW] = fifo_read_data_i & lane_mask;
          // A message ending on a block boundary ships its last data block unpadded.
          if (cap_last_q && !boundary_q) begin
            state_d = StPad;
          end else if (lane_cap_q == LaneIdxW'(RateLanes - 1)) begin
            state_d = StEmit;
          end
        end else if (words_issued_q == words_total_q) begin
          state_d = StPad;
        end
      end
      StPad: begin
        buf_d        = padded;
        block_last_d = 1'b1;
        state_d      = StEmit;
      end
      StEmit: begin
        if (block_ready_i) begin
          if (block_last_q) begin
            state_d = StDone;
          end else begin
            buf_d        = '0;
            lane_issue_d = '0;
            lane_cap_d   = '0;
            state_d      = StFill;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      msg_rem_q      <= '0;
      words_total_q  <= '0;
      words_issued_q <= '0;
      pad_off_q      <= '0;
      boundary_q     <= 1'b0;
      lane_issue_q   <= '0;
      lane_cap_q     <= '0;
      cap_q          <= 1'b0;
      cap_last_q     <= 1'b0;
      buf_q          <= '0;
      block_last_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      msg_rem_q      <= msg_rem_d;
      words_total_q  <= words_total_d;
      words_issued_q <= words_issued_d;
      pad_off_q      <= pad_off_d;
      boundary_q     <= boundary_d;
      lane_issue_q   <= lane_issue_d;
      lane_cap_q     <= lane_cap_d;
      cap_q          <= cap_d;
      cap_last_q     <= cap_last_d;
      buf_q          <= buf_d;
      block_last_q   <= block_last_d;
    end
  end

  assign fifo_read_en_o = pop;
  assign block_data_o   = buf_q;
  assign block_valid_o  = (state_q == StEmit);
  assign block_last_o   = block_last_q;
  assign busy_o         = (state_q == StFill) || (state_q == StPad) || (state_q == StEmit);
  assign done_o         = (state_q == StDone);

endmodule
